// File: rtl/rx_fifo_if.sv
// Handshake bundle between the UART receiver/consumer and rx_fifo.
// master drives push/pop requests, slave is the buffer.
interface rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd;
  logic                  clr_overflow;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;

  modport master (
    output wr, w_data, rd, clr_overflow,
    input  r_data, empty, full, count, overflow
  );

  modport slave (
    input  wr, w_data, rd, clr_overflow,
    output r_data, empty, full, count, overflow
  );
endinterface

// File: rtl/rx_fifo.sv
// Circular byte buffer behind the UART receiver.
// FWFT read port, registered flags, sticky overflow.
module rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  rx_fifo_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, full_q, ovf_q;
  logic                  do_wr, do_rd, ovf_set;

  // A full buffer still accepts a push when a pop frees a slot.
  assign do_rd   = bus.rd && !empty_q;
  assign do_wr   = bus.wr && (!full_q || do_rd);
  assign ovf_set = bus.wr && full_q && !bus.rd;

  always_comb begin
    count_d = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (do_rd) r_ptr <= r_ptr + ADDR_WIDTH'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (bus.clr_overflow)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[w_ptr] <= bus.w_data;
  end

  assign bus.r_data   = mem[r_ptr];
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: queue model plus
// directed vectors with literal expectations.
module tb_rx_fifo;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  rx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a plain queue holding the stored words in order.
  logic [7:0] mq[$];
  logic       m_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      automatic int  sz  = mq.size();
      automatic bit  rdv = bus.rd && (sz > 0);
      automatic bit  wrv = bus.wr && ((sz < 16) || rdv);
      if (rdv) void'(mq.pop_front());
      if (wrv) mq.push_back(bus.w_data);
      if (bus.wr && (sz == 16) && !bus.rd)
        m_ovf = 1'b1;
      else if (bus.clr_overflow)
        m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_count", 32'(bus.count), 32'(mq.size()));
      chk("m_empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("m_full", 32'(bus.full), 32'(mq.size() == 16));
      chk("m_ovf", 32'(bus.overflow), 32'(m_ovf));
      if (mq.size() > 0)
        chk("m_rdata", 32'(bus.r_data), 32'(mq[0]));
    end
  end

  task automatic drive(input logic w, input logic [7:0] d,
                       input logic r, input logic c);
    bus.wr           = w;
    bus.w_data       = d;
    bus.rd           = r;
    bus.clr_overflow = c;
    @(posedge clk);
    #1;
  endtask

  int pushes, pops, iter;
  logic w_en, r_en;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.wr = 1'b0;
    bus.w_data = '0;
    bus.rd = 1'b0;
    bus.clr_overflow = 1'b0;
    #12;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    bus.wr = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_full", 32'(bus.full), 32'd0);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_rdata", 32'(bus.r_data), 32'hA5);
    chk("a5_count", 32'(bus.count), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_pop_empty", 32'(bus.empty), 32'd1);

    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);

    drive(1'b1, 8'h55, 1'b0, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd16);

    for (int i = 0; i < 16; i++) begin
      chk("drain_rdata", 32'(bus.r_data), 32'(i));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_full", 32'(bus.full), 32'd0);

    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    drive(1'b1, 8'h66, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", 32'(bus.overflow), 32'd0);

    drive(1'b1, 8'h77, 1'b1, 1'b0);
    chk("rw_full_count", 32'(bus.count), 32'd16);
    chk("rw_full_ovf", 32'(bus.overflow), 32'd0);
    chk("rw_full_head", 32'(bus.r_data), 32'h21);
    for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rw_full_tail", 32'(bus.r_data), 32'h77);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rw_full_drained", 32'(bus.empty), 32'd1);

    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("rw_empty_count", 32'(bus.count), 32'd1);
    chk("rw_empty_rdata", 32'(bus.r_data), 32'h3C);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_pop_count", 32'(bus.count), 32'd0);
    drive(1'b1, 8'h9E, 1'b0, 1'b0);
    chk("after_empty_pop", 32'(bus.r_data), 32'h9E);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    pushes = 0;
    pops   = 0;
    iter   = 0;
    while ((pushes < 40 || pops < 40) && iter < 2000) begin
      r_en = (pops < 40) && (mq.size() > 0) &&
             ($urandom_range(0, 2) != 0);
      w_en = (pushes < 40) && ((mq.size() < 16) || r_en) &&
             ($urandom_range(0, 2) != 0);
      drive(w_en, 8'(pushes * 7 + 3), r_en, 1'b0);
      if (w_en) pushes++;
      if (r_en) pops++;
      iter++;
    end
    chk("rand_done", 32'(pushes + pops), 32'd80);
    chk("rand_empty", 32'(bus.empty), 32'd1);

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_fifo.md
# rx_fifo

Byte buffer that sits directly downstream of the UART receiver. Each received byte, qualified by the receiver's one-cycle done tick, is captured into a circular buffer. The buffer is then drained by the consumer (host logic or a command decoder) through a first-word-fall-through read port. It decouples the serial receive rate from consumer latency and flags lost bytes with a sticky overflow bit.

## Interface

Parameters:
- DATA_WIDTH, 8, width of each stored word; matches the receiver's data output.
- ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH = 16 entries.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  push request; driven by the receiver's rx_done_tick (one-cycle pulse).
- w_data  input  DATA_WIDTH  word to push; sampled on the clk edge where wr=1.
- rd  input  1  pop request; one entry is removed per cycle while rd=1 and empty=0.
- r_data  output  DATA_WIDTH  oldest stored word (head); valid only while empty=0.
- empty  output  1  buffer holds 0 entries.
- full  output  1  buffer holds 2**ADDR_WIDTH entries.
- count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow  output  1  sticky: a push was dropped because the buffer was full.
- clr_overflow  input  1  synchronous clear of overflow.

## Operation

- Storage: register array of 2**ADDR_WIDTH words, not reset. Write pointer w_ptr and read pointer r_ptr are ADDR_WIDTH bits wide and wrap modulo depth (15 -> 0).
- r_data = mem[r_ptr], combinational from the array (first-word-fall-through).
- empty, full and count are registered and updated in the same edge as the pointers.
- Per-cycle action, decided on {wr, rd}:
  - 00: no change.
  - 10, not full: mem[w_ptr] <= w_data, w_ptr+1, count+1.
  - 10, full: word dropped, pointers and count unchanged, overflow <= 1.
  - 01, not empty: r_ptr+1, count-1.
  - 01, empty: ignored. No underflow flag; pointers unchanged.
  - 11, empty: write only; the read is ignored; count 0 -> 1.
  - 11, full: read and write both performed; count stays at depth; no overflow.
  - 11, otherwise: both performed; count unchanged.
- Flag derivation: empty_next = (count_next == 0); full_next = (count_next == 2**ADDR_WIDTH).
- overflow: set as above. Cleared when clr_overflow=1. If a set and a clear occur in the same cycle, set wins.
- Reset (async, any time, including mid-burst): w_ptr=0, r_ptr=0, count=0, empty=1, full=0, overflow=0. Stored data is discarded logically; array contents are don't-care.

## Timing

- Write latency: wr=1 at edge N means that after edge N, empty=0 and r_data shows the word if the buffer was previously empty (1 cycle).
- Pop: rd=1 at edge N means the next entry appears on r_data after edge N. The consumer reads r_data in the same cycle it asserts rd.
- Throughput: 1 push and 1 pop per cycle sustained.
- The receiver's wr pulses are spaced at least one full UART frame apart. Back-to-back wr on consecutive cycles must still be handled correctly.
- No combinational path from wr or rd to empty, full or count; those are register outputs only.

## Test plan

- Reset: assert reset mid-operation with count=5 -> immediately empty=1, full=0, count=0, overflow=0. After release, a push of 0xA5 gives r_data=0xA5 and count=1 one cycle later.
- Fill/drain order: push 0x00..0x0F on 16 consecutive cycles -> full=1, count=16. Pop 16 times -> r_data sequence 0x00..0x0F, then empty=1 and full=0.
- Overflow: from full, push 0x55 with rd=0 -> overflow=1, count=16, and the next 16 pops return 0x00..0x0F (0x55 absent). Pulse clr_overflow -> overflow=0. Same-cycle set and clear -> overflow=1.
- Simultaneous ops: rd=wr=1 when empty with w_data=0x3C -> count=1, r_data=0x3C. rd=wr=1 when full -> count=16, overflow=0, head advances to the next word, 0x?? written at the tail.
- Pointer wrap: run 40 pushes and 40 pops interleaved with random gaps while occupancy stays within 0..16 -> data order preserved across multiple wraps; count matches a reference model every cycle.
- Empty pop: rd=1 with empty=1 for 3 cycles -> pointers unchanged, count=0; the next push/pop pair returns the pushed value.
